// File: rtl/game_pkg.sv
// Shared Road Fighter constants: race state encoding, speed/distance widths, player car geometry.
// Pure declarations; no latency, no flow control.
package game_pkg;

  localparam int SPEED_W     = 4;
  localparam int DIST_W      = 16;
  localparam int MAX_SPEED   = 8;
  localparam int START_LIVES = 3;

  localparam int CAR_W       = 16;
  localparam int CAR_H       = 32;
  localparam int TRACK_W     = 255;
  localparam int CAR_START_X = (TRACK_W - CAR_W) / 2;
  localparam int CAR_START_Y = 400;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RACE      = 3'd2,
    ST_CRASH     = 3'd3,
    ST_RESPAWN   = 3'd4,
    ST_GAMEOVER  = 3'd5
  } race_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/race_controller_if.sv
// Button/frame inputs and status outputs of the race sequencer, grouped as one bundle.
// Levels and single-clk pulses only; no handshake or backpressure.
interface race_controller_if;
  import game_pkg::*;

  logic                frame_tick;
  logic                start;
  logic                accel;
  logic                brake;
  logic                collision;
  logic                player_update;
  logic                player_respawn;
  logic [SPEED_W-1:0]  speed;
  logic [DIST_W-1:0]   distance;
  logic [1:0]          lives;
  logic [2:0]          state;
  logic                game_over;

  modport master (
    output frame_tick, start, accel, brake, collision,
    input  player_update, player_respawn, speed, distance, lives, state, game_over
  );

  modport slave (
    input  frame_tick, start, accel, brake, collision,
    output player_update, player_respawn, speed, distance, lives, state, game_over
  );

endinterface

// File: rtl/speed_governor.sv
// Player speed register plus held-accel counter; steps once per qualified frame tick.
// Speed visible one clk after the tick; force_zero beats clear beats frame_tick.
module speed_governor import game_pkg::*; #(
  parameter int ACCEL_FRAMES = 8,
  parameter int MAX_SPEED    = game_pkg::MAX_SPEED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               accel,
  input  logic               brake,
  input  logic               force_zero,
  input  logic               clear,
  output logic [SPEED_W-1:0] speed
);

  localparam int ACW = $clog2(ACCEL_FRAMES + 1);

  logic [ACW-1:0] accel_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed     <= '0;
      accel_cnt <= '0;
    end else if (force_zero) begin
      speed     <= '0;
      accel_cnt <= '0;
    end else if (clear) begin
      accel_cnt <= '0;
    end else if (frame_tick) begin
      if (brake) begin
        if (speed != '0) speed <= speed - 1'b1;
        accel_cnt <= '0;
      end else if (accel) begin
        if (accel_cnt == ACW'(ACCEL_FRAMES - 1)) begin
          accel_cnt <= '0;
          if (speed < SPEED_W'(MAX_SPEED)) speed <= speed + 1'b1;
        end else begin
          accel_cnt <= accel_cnt + 1'b1;
        end
      end else begin
        accel_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/race_controller.sv
// Road Fighter race sequencer: state machine, distance, lives and player car pacing.
// All outputs registered (1 clk after the causing input); no backpressure.
module race_controller import game_pkg::*; #(
  parameter int COUNT_FRAMES = 180,
  parameter int CRASH_FRAMES = 90,
  parameter int ACCEL_FRAMES = 8,
  parameter int MAX_SPEED    = game_pkg::MAX_SPEED,
  parameter int START_LIVES  = game_pkg::START_LIVES
) (
  input  logic             clk,
  input  logic             reset,
  race_controller_if.slave bus
);

  localparam int FCW = $clog2(max_int(COUNT_FRAMES, CRASH_FRAMES) + 1);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

  race_state_t         state, state_n;
  logic [FCW-1:0]      frame_cnt, frame_cnt_n;
  logic [DIST_W-1:0]   distance, distance_n;
  logic [1:0]          lives, lives_n;
  logic                player_update, update_n;
  logic                player_respawn, respawn_n;
  logic                game_over, game_over_n;
  logic [DIST_W:0]     dist_sum;
  logic [SPEED_W-1:0]  speed;
  logic                gov_tick, gov_zero, gov_clear;

  speed_governor #(
    .ACCEL_FRAMES (ACCEL_FRAMES),
    .MAX_SPEED    (MAX_SPEED)
  ) u_speed_governor (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (gov_tick),
    .accel      (bus.accel),
    .brake      (bus.brake),
    .force_zero (gov_zero),
    .clear      (gov_clear),
    .speed      (speed)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      frame_cnt      <= '0;
      distance       <= '0;
      lives          <= LIVES_INIT;
      player_update  <= 1'b0;
      player_respawn <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      state          <= state_n;
      frame_cnt      <= frame_cnt_n;
      distance       <= distance_n;
      lives          <= lives_n;
      player_update  <= update_n;
      player_respawn <= respawn_n;
      game_over      <= game_over_n;
    end
  end

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    distance_n  = distance;
    lives_n     = lives;
    update_n    = 1'b0;
    respawn_n   = 1'b0;
    gov_tick    = 1'b0;
    gov_zero    = 1'b0;
    gov_clear   = 1'b0;
    dist_sum    = {1'b0, distance} + {{(DIST_W + 1 - SPEED_W){1'b0}}, speed};

    case (state)
      ST_IDLE, ST_GAMEOVER: begin
        if (bus.start) begin
          state_n    = ST_COUNTDOWN;
          lives_n    = LIVES_INIT;
          distance_n = '0;
          gov_zero   = 1'b1;
          respawn_n  = 1'b1;
        end
      end
      ST_COUNTDOWN: begin
        if (bus.frame_tick) begin
          if (frame_cnt == FCW'(COUNT_FRAMES - 1)) state_n = ST_RACE;
          else                                     frame_cnt_n = frame_cnt + 1'b1;
        end
      end
      ST_RACE: begin
        // A collision swallows a coincident frame tick entirely.
        if (bus.collision) begin
          gov_zero = 1'b1;
          lives_n  = lives - 2'd1;
          state_n  = (lives == 2'd1) ? ST_GAMEOVER : ST_CRASH;
        end else if (bus.frame_tick) begin
          gov_tick   = 1'b1;
          update_n   = (speed != '0);
          distance_n = dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];
        end
      end
      ST_CRASH: begin
        if (bus.frame_tick) begin
          if (frame_cnt == FCW'(CRASH_FRAMES - 1)) begin
            state_n   = ST_RESPAWN;
            respawn_n = 1'b1;
          end else begin
            frame_cnt_n = frame_cnt + 1'b1;
          end
        end
      end
      ST_RESPAWN: begin
        state_n   = ST_RACE;
        gov_clear = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n != state) frame_cnt_n = '0;
    game_over_n = (state_n == ST_GAMEOVER);
  end

  assign bus.player_update  = player_update;
  assign bus.player_respawn = player_respawn;
  assign bus.speed          = speed;
  assign bus.distance       = distance;
  assign bus.lives          = lives;
  assign bus.state          = state;
  assign bus.game_over      = game_over;

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller: vector table for speed control plus hand-written
// sequences for countdown, crash/respawn, game over, async reset and distance saturation.
module tb_race_controller;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  race_controller_if bus();

  race_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_speed, m_cnt, m_dist;

  typedef struct {
    logic        tk, st, ac, br, co;
    logic [2:0]  e_state;
    logic [3:0]  e_speed;
    logic        e_upd;
    logic [15:0] e_dist;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic tk, input logic st, input logic ac, input logic br, input logic co);
    @(negedge clk);
    bus.frame_tick = tk;
    bus.start      = st;
    bus.accel      = ac;
    bus.brake      = br;
    bus.collision  = co;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.accel      = 1'b0;
    bus.brake      = 1'b0;
    bus.collision  = 1'b0;
  endtask

  // One RACE frame tick with the reference speed/distance model advanced alongside.
  task automatic race_tick(input logic ac, input logic br, output logic exp_upd);
    exp_upd = (m_speed > 0);
    step(1'b1, 1'b0, ac, br, 1'b0);
    m_dist = (m_dist + m_speed > 65535) ? 65535 : m_dist + m_speed;
    if (br) begin
      if (m_speed > 0) m_speed--;
      m_cnt = 0;
    end else if (ac) begin
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0;
        if (m_speed < 8) m_speed++;
      end
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic countdown();
    int bad;
    bad = 0;
    for (int i = 1; i <= 180; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.player_update !== 1'b0 || bus.player_respawn !== 1'b0) bad++;
      if (i < 180) begin
        if (bus.state !== 3'd1) bad++;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    check("countdown_quiet", bad, 0);
    check("race_on_180th_tick", bus.state, 3'd2);
    m_speed = 0;
    m_cnt   = 0;
  endtask

  task automatic crash_wait();
    int bad;
    bad = 0;
    for (int i = 1; i <= 90; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, (i == 10));
      if (i < 90) begin
        if (bus.state !== 3'd3 || bus.speed !== 4'd0 || bus.player_update !== 1'b0 ||
            bus.player_respawn !== 1'b0) bad++;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    check("crash_quiet", bad, 0);
    check("respawn_state", bus.state, 3'd4);
    check("respawn_pulse", bus.player_respawn, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("race_after_respawn", bus.state, 3'd2);
    check("respawn_pulse_end", bus.player_respawn, 1'b0);
    m_speed = 0;
    m_cnt   = 0;
  endtask

  initial begin
    logic eu;
    int   bad, n_upd;

    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.accel      = 1'b0;
    bus.brake      = 1'b0;
    bus.collision  = 1'b0;
    reset = 1'b1;
    #12;
    check("rst_state", bus.state, 3'd0);
    check("rst_speed", bus.speed, 4'd0);
    check("rst_distance", bus.distance, 16'd0);
    check("rst_lives", bus.lives, 2'd3);
    check("rst_pulses", {bus.player_update, bus.player_respawn, bus.game_over}, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // 1: start and countdown
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("start_state", bus.state, 3'd1);
    check("start_respawn", bus.player_respawn, 1'b1);
    check("start_lives", bus.lives, 2'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_respawn_1clk", bus.player_respawn, 1'b0);
    countdown();
    m_dist = 0;

    // 2: hold accel for 80 ticks
    n_upd = 0;
    for (int i = 1; i <= 80; i++) begin
      race_tick(1'b1, 1'b0, eu);
      check("accel_speed", bus.speed, m_speed);
      check("accel_update", bus.player_update, eu);
      if (bus.player_update === 1'b1) n_upd++;
    end
    check("accel_dist_model", bus.distance, m_dist);
    check("accel_dist_352", bus.distance, 16'd352);
    check("accel_speed_sat", bus.speed, 4'd8);
    check("accel_update_count", n_upd, 72);

    // 3: brake down to 5, then table-driven brake+accel and counter checks
    for (int i = 0; i < 3; i++) race_tick(1'b0, 1'b1, eu);
    check("brake_speed5", bus.speed, 4'd5);
    check("brake_dist", bus.distance, 16'd373);

    vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'd4, 1'b1, 16'd378};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'd3, 1'b1, 16'd382};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'd2, 1'b1, 16'd385};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'd2, 1'b0, 16'd385};
    for (int i = 4; i <= 10; i++)
      vt[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'd2, 1'b1, 16'(385 + 2 * (i - 3))};
    vt[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'd3, 1'b1, 16'd401};
    vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd3, 1'b1, 16'd404};
    vt[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd3, 1'b0, 16'd404};

    for (int i = 0; i < 14; i++) begin
      step(vt[i].tk, vt[i].st, vt[i].ac, vt[i].br, vt[i].co);
      check($sformatf("vec%0d_state", i), bus.state, vt[i].e_state);
      check($sformatf("vec%0d_speed", i), bus.speed, vt[i].e_speed);
      check($sformatf("vec%0d_update", i), bus.player_update, vt[i].e_upd);
      check($sformatf("vec%0d_distance", i), bus.distance, vt[i].e_dist);
    end

    // 4: collision together with a frame tick
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("coll_no_update", bus.player_update, 1'b0);
    check("coll_lives", bus.lives, 2'd2);
    check("coll_speed", bus.speed, 4'd0);
    check("coll_state", bus.state, 3'd3);
    check("coll_dist", bus.distance, 16'd404);
    crash_wait();
    check("crash_dist_kept", bus.distance, 16'd404);
    check("crash_lives_kept", bus.lives, 2'd2);

    // 5: lose the remaining lives
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("coll2_lives", bus.lives, 2'd1);
    crash_wait();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("go_state", bus.state, 3'd5);
    check("go_flag", bus.game_over, 1'b1);
    check("go_lives", bus.lives, 2'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("go_frozen_state", bus.state, 3'd5);
    check("go_frozen", {bus.lives, bus.speed, bus.player_update}, {2'd0, 4'd0, 1'b0});
    check("go_frozen_dist", bus.distance, 16'd404);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_state", bus.state, 3'd1);
    check("restart_lives", bus.lives, 2'd3);
    check("restart_dist", bus.distance, 16'd0);
    check("restart_respawn", bus.player_respawn, 1'b1);
    check("restart_go_clear", bus.game_over, 1'b0);

    // 6a: async reset in the middle of a crash
    countdown();
    m_dist = 0;
    for (int i = 0; i < 16; i++) race_tick(1'b1, 1'b0, eu);
    check("pre_reset_dist", bus.distance, 16'd8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_state", bus.state, 3'd3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", bus.state, 3'd0);
    check("async_rst_lives", bus.lives, 2'd3);
    check("async_rst_dist", bus.distance, 16'd0);
    check("async_rst_pulses", {bus.player_update, bus.player_respawn, bus.game_over}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.player_respawn !== 1'b0 || bus.state !== 3'd0) bad++;
    end
    check("post_reset_quiet", bad, 0);

    // 6b: distance saturation
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    countdown();
    m_dist = 0;
    for (int i = 0; i < 64; i++) race_tick(1'b1, 1'b0, eu);
    check("sat_pre_speed", bus.speed, 4'd8);
    check("sat_pre_dist", bus.distance, 16'd224);
    for (int i = 0; i < 8163; i++) race_tick(1'b1, 1'b0, eu);
    check("sat_fff8", bus.distance, 16'hFFF8);
    race_tick(1'b1, 1'b0, eu);
    check("sat_ffff", bus.distance, 16'hFFFF);
    check("sat_update", bus.player_update, 1'b1);
    race_tick(1'b1, 1'b0, eu);
    check("sat_hold", bus.distance, 16'hFFFF);
    check("sat_model", bus.distance, m_dist);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
